servant_gpio_uart_rx: RTL and testbench
=======================================

// Module: servant_gpio_uart_rx
// PURPOSE
//  Downstream consumer of the servant GPIO output bus in simulation/FPGA benches.
//  Decodes a bit-banged 8N1 UART stream driven by firmware on one GPIO bit.
//  Buffers received bytes in a small FIFO and presents them on a valid/ready byte stream.
//  Flags framing errors and FIFO overflow for the bench or a console printer.
// PARAMETERS
//  NUM_GPIO      8    width of the GPIO bus from servant
//  RX_BIT        0    index of the GPIO bit carrying UART TX from firmware
//  CLKS_PER_BIT  87   wb_clk cycles per UART bit; legal range >= 4
//  FIFO_DEPTH    4    byte FIFO entries; power of 2, >= 2
// PORTS
//  wb_clk       in   1         system clock
//  wb_rst       in   1         synchronous reset, active high
//  i_gpio       in   NUM_GPIO  GPIO bus from servant (q)
//  o_data       out  8         head-of-FIFO byte
//  o_valid      out  1         FIFO non-empty
//  i_ready      in   1         consumer accepts o_data when o_valid & i_ready
//  o_frame_err  out  1         1-cycle pulse: stop bit sampled low
//  o_overflow   out  1         sticky: byte dropped because FIFO full
// BEHAVIOUR
//  Reset (wb_rst=1 at posedge, one clock; one clock and reset only): state=IDLE, FIFO empty, o_valid=0,
//   o_data=0, o_frame_err=0, o_overflow=0, rx sample reg=1 (idle high).
//  Reset mid-frame or with FIFO occupied: partial byte and FIFO contents discarded.
//  Input: i_gpio[RX_BIT] registered once (rx_q); all decoding uses rx_q.
//  Bit counter: width $clog2(CLKS_PER_BIT)+1, counts 0..limit-1 then reloads 0.
//  FSM:
//   IDLE     : rx_q==0 -> START, cnt=0.
//   START    : after CLKS_PER_BIT/2 (floor) cycles sample rx_q; 0 -> DATA (bit=0,
//              cnt=0); 1 -> IDLE (glitch rejected, no flag).
//   DATA     : every CLKS_PER_BIT cycles sample rx_q into shift reg, LSB first;
//              after bit 7 -> STOP.
//   STOP     : after CLKS_PER_BIT cycles sample rx_q; 1 -> push byte, IDLE;
//              0 -> o_frame_err pulse, byte discarded, WAIT_HI.
//   WAIT_HI  : stay until rx_q==1, then IDLE (prevents break re-triggering).
//  Sampling lands mid-bit: start edge seen at cycle t0 (rx_q), data bit n sampled at
//   t0+CLKS_PER_BIT/2+(n+1)*CLKS_PER_BIT, stop at +9*CLKS_PER_BIT.
//  Latency: o_valid rises (empty FIFO) the cycle after the stop-bit sample cycle.
//  FIFO: circular, ptr width $clog2(FIFO_DEPTH)+1 with wrap bit; full when ptr MSBs
//   differ and low bits equal; empty when equal. Pointers wrap modulo 2*DEPTH.
//  Pop: o_valid & i_ready at posedge; o_data shows next entry next cycle.
//  Push when full and no pop that cycle: byte dropped, o_overflow<=1 until reset.
//  Simultaneous push and pop when full: pop frees slot, push accepted, no overflow.
//  Simultaneous push and pop when empty: pop ignored (o_valid=0), byte stored.
//  i_ready while o_valid=0: no effect. o_data holds while o_valid & !i_ready.
//  Other GPIO bits ignored. UART decoding never stalls on FIFO state.
// TESTING
//  1 Reset then drive 0x55 on q[0] at CLKS_PER_BIT=87, i_ready=1 -> o_data=0x55, o_valid
//    high exactly 1 cycle, rising 1 cycle after stop sample; no flags.
//  2 i_ready=0, send 0x41,0x42,0x43,0x44,0x45 (DEPTH=4) -> o_overflow=1 after 5th stop;
//    then pop in order 0x41..0x44, o_valid drops after 4th.
//  3 Low glitch of 20 cycles on q[0] from idle -> state returns IDLE, no byte, no flags.
//  4 Send 0xA5 with stop bit forced 0 for 3 bit times -> one o_frame_err pulse, no push,
//    next valid frame 0x3C received correctly.
//  5 Assert wb_rst during data bit 4 of 0xFF with 2 bytes queued -> o_valid=0, FIFO
//    empty; following 0x12 decodes correctly.
//  6 FIFO full, i_ready=1 on same cycle as new stop sample -> byte accepted, no overflow;
//    run 16 bytes 0x00..0x0F through pointer wrap -> in-order, no loss.

Source files
------------

// File: rtl/servant_gpio_uart_rx.sv
// servant_gpio_uart_rx
//   Decodes an 8N1 UART stream that firmware bit-bangs on one bit of the
//   servant GPIO bus. Received bytes are queued in a small circular FIFO and
//   presented on a valid/ready byte stream. Framing errors and FIFO overflow
//   are flagged for the bench or a console printer.
//
// Parameters
//   NUM_GPIO      width of the GPIO bus
//   RX_BIT        GPIO bit carrying the UART line
//   CLKS_PER_BIT  wb_clk cycles per UART bit (>= 4)
//   FIFO_DEPTH    byte FIFO entries (power of 2, >= 2)
//
// Ports
//   wb_clk       system clock
//   wb_rst       synchronous reset, active high
//   i_gpio       GPIO bus from servant
//   o_data       head-of-FIFO byte (0 while empty)
//   o_valid      FIFO non-empty
//   i_ready      consumer takes o_data when o_valid & i_ready
//   o_frame_err  one-cycle pulse: stop bit sampled low
//   o_overflow   sticky: a byte was dropped because the FIFO was full
module servant_gpio_uart_rx #(
    parameter int NUM_GPIO     = 8,
    parameter int RX_BIT       = 0,
    parameter int CLKS_PER_BIT = 87,
    parameter int FIFO_DEPTH   = 4
) (
    input  logic                wb_clk,
    input  logic                wb_rst,
    input  logic [NUM_GPIO-1:0] i_gpio,
    output logic [7:0]          o_data,
    output logic                o_valid,
    input  logic                i_ready,
    output logic                o_frame_err,
    output logic                o_overflow
);

    localparam int CW = $clog2(CLKS_PER_BIT) + 1;
    localparam int AW = $clog2(FIFO_DEPTH);
    localparam logic [CW-1:0] BIT_LAST  = CW'(CLKS_PER_BIT - 1);
    localparam logic [CW-1:0] HALF_LAST = CW'(CLKS_PER_BIT / 2 - 1);

    typedef enum logic [2:0] {IDLE, START, DATA, STOP, WAIT_HI} state_t;

    state_t        state, state_nxt;
    logic [CW-1:0] cnt, cnt_nxt;
    logic [2:0]    bit_idx, bit_idx_nxt;
    logic [7:0]    shift, shift_nxt;
    logic          rx_q;
    logic          push;
    logic          frame_err_nxt;

    // Only RX_BIT is decoded; the remaining GPIO bits are deliberately ignored.
    logic unused_gpio;
    assign unused_gpio = ^i_gpio;

    // Input stage: single register on the line, idles high.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) rx_q <= 1'b1;
        else        rx_q <= i_gpio[RX_BIT];
    end

    // Receiver FSM: next state and sample points. The counter restarts at
    // every sample so each wait is measured from the previous sample.
    always_comb begin
        state_nxt     = state;
        cnt_nxt       = cnt + 1'b1;
        bit_idx_nxt   = bit_idx;
        shift_nxt     = shift;
        push          = 1'b0;
        frame_err_nxt = 1'b0;
        case (state)
            IDLE: begin
                cnt_nxt = '0;
                if (!rx_q) state_nxt = START;
            end
            START: begin
                if (cnt == HALF_LAST) begin
                    cnt_nxt     = '0;
                    bit_idx_nxt = 3'd0;
                    // A line back high at mid start bit is a glitch, not a frame.
                    state_nxt   = rx_q ? IDLE : DATA;
                end
            end
            DATA: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt     = '0;
                    shift_nxt   = {rx_q, shift[7:1]};
                    bit_idx_nxt = bit_idx + 1'b1;
                    if (bit_idx == 3'd7) state_nxt = STOP;
                end
            end
            STOP: begin
                if (cnt == BIT_LAST) begin
                    cnt_nxt = '0;
                    if (rx_q) begin
                        push      = 1'b1;
                        state_nxt = IDLE;
                    end else begin
                        frame_err_nxt = 1'b1;
                        state_nxt     = WAIT_HI;
                    end
                end
            end
            WAIT_HI: begin
                // Hold off until the line idles so a break is not seen as starts.
                cnt_nxt = '0;
                if (rx_q) state_nxt = IDLE;
            end
            default: begin
                cnt_nxt   = '0;
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM control registers.
    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            state       <= IDLE;
            cnt         <= '0;
            bit_idx     <= 3'd0;
            o_frame_err <= 1'b0;
        end else begin
            state       <= state_nxt;
            cnt         <= cnt_nxt;
            bit_idx     <= bit_idx_nxt;
            o_frame_err <= frame_err_nxt;
        end
    end

    // Shift register holds data only; its contents are meaningless until a push.
    always_ff @(posedge wb_clk) begin
        shift <= shift_nxt;
    end

    // Byte FIFO: pointers carry an extra wrap bit to tell full from empty.
    logic [7:0]  mem [FIFO_DEPTH];
    logic [AW:0] wr_ptr, rd_ptr;
    logic        empty, full, pop, wr_en;

    assign empty = (wr_ptr == rd_ptr);
    assign full  = (wr_ptr[AW] != rd_ptr[AW]) && (wr_ptr[AW-1:0] == rd_ptr[AW-1:0]);
    assign pop   = o_valid & i_ready;
    // A pop in the same cycle frees the slot the push needs.
    assign wr_en = push && (!full || pop);

    assign o_valid = !empty;
    assign o_data  = empty ? 8'h00 : mem[rd_ptr[AW-1:0]];

    always_ff @(posedge wb_clk) begin
        if (wb_rst) begin
            wr_ptr     <= '0;
            rd_ptr     <= '0;
            o_overflow <= 1'b0;
        end else begin
            if (wr_en) wr_ptr <= wr_ptr + 1'b1;
            if (pop)   rd_ptr <= rd_ptr + 1'b1;
            if (push && full && !pop) o_overflow <= 1'b1;
        end
    end

    always_ff @(posedge wb_clk) begin
        if (wr_en) mem[wr_ptr[AW-1:0]] <= shift;
    end

endmodule

// File: tb/tb_servant_gpio_uart_rx.sv
// Directed bench for servant_gpio_uart_rx at CLKS_PER_BIT=87, FIFO_DEPTH=4.
// Inputs are driven and outputs observed on the falling clock edge.
module tb_servant_gpio_uart_rx;

    localparam int C = 87;
    // Observation index (within a frame) at which a pushed byte first shows:
    // start seen at posedge 1, stop sampled at posedge 1+43+9*87=827, visible
    // at the falling edge that follows, i.e. frame index 828.
    localparam int VALID_AT = 828;

    logic       clk = 1'b0;
    logic       rst = 1'b0;
    logic [7:0] gpio = 8'hFF;
    logic [7:0] data;
    logic       valid;
    logic       ready = 1'b0;
    logic       ferr;
    logic       ovf;

    always #5 clk = ~clk;

    servant_gpio_uart_rx #(
        .NUM_GPIO(8), .RX_BIT(0), .CLKS_PER_BIT(C), .FIFO_DEPTH(4)
    ) dut (
        .wb_clk(clk), .wb_rst(rst), .i_gpio(gpio),
        .o_data(data), .o_valid(valid), .i_ready(ready),
        .o_frame_err(ferr), .o_overflow(ovf)
    );

    int n_assert = 0;
    int n_fail   = 0;

    int         cur_i = -1;
    int         vfirst, vcount, ferr_cnt, ferr_at;
    logic [7:0] vdata;
    logic [7:0] popq [$];

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_assert++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic mon_clear();
        vfirst   = -1;
        vcount   = 0;
        ferr_cnt = 0;
        ferr_at  = -1;
        vdata    = 8'h00;
        popq.delete();
    endtask

    // One clock: drive line/ready/reset, then record what the DUT shows.
    // Other GPIO bits carry noise to confirm they are ignored.
    task automatic tick(input logic line, input logic rdy, input logic r);
        logic [6:0] noise;
        @(negedge clk);
        noise = 7'($urandom_range(0, 127));
        gpio  = {noise, line};
        ready = rdy;
        rst   = r;
        if (valid) begin
            vcount++;
            if (vfirst < 0) begin
                vfirst = cur_i;
                vdata  = data;
            end
        end
        if (ferr) begin
            ferr_cnt++;
            ferr_at = cur_i;
        end
        if (valid && ready) popq.push_back(data);
    endtask

    task automatic idle(input int n, input logic rdy);
        cur_i = -1;
        repeat (n) tick(1'b1, rdy, 1'b0);
    endtask

    task automatic do_reset();
        cur_i = -1;
        tick(1'b1, 1'b0, 1'b1);
        tick(1'b1, 1'b0, 1'b0);
    endtask

    // One 8N1 frame; stop level/length selectable. pop_at forces i_ready
    // high on that index only; rst_at pulses reset there and abandons the frame.
    task automatic send_frame(input logic [7:0] b, input logic stopv, input int stop_cyc,
                              input logic rdy, input int pop_at, input int rst_at);
        for (int i = 0; i < 9 * C + stop_cyc; i++) begin
            int   bi;
            logic line;
            bi    = i / C;
            line  = (bi == 0) ? 1'b0 : (bi <= 8) ? b[bi-1] : stopv;
            cur_i = i;
            tick(line, (i == pop_at) ? 1'b1 : rdy, (i == rst_at));
            if (i == rst_at) break;
        end
        cur_i = -1;
    endtask

    initial begin
        idle(3, 1'b0);
        do_reset();
        check("reset_valid", valid, 0);
        check("reset_data", data, 8'h00);
        check("reset_ferr", ferr, 0);
        check("reset_ovf", ovf, 0);

        // 1: single byte, consumer always ready
        mon_clear();
        send_frame(8'h55, 1'b1, C, 1'b1, -1, -1);
        idle(20, 1'b1);
        check("t1_valid_rise", vfirst, VALID_AT);
        check("t1_valid_len", vcount, 1);
        check("t1_data", vdata, 8'h55);
        check("t1_ferr", ferr_cnt, 0);
        check("t1_ovf", ovf, 0);
        check("t1_pops", popq.size(), 1);

        // 2: fill past depth with consumer stalled
        mon_clear();
        for (int k = 0; k < 4; k++) send_frame(8'h41 + 8'(k), 1'b1, C, 1'b0, -1, -1);
        idle(5, 1'b0);
        check("t2_ovf_at_full", ovf, 0);
        check("t2_valid_full", valid, 1);
        check("t2_head", data, 8'h41);
        send_frame(8'h45, 1'b1, C, 1'b0, -1, -1);
        idle(5, 1'b0);
        check("t2_ovf_after_5th", ovf, 1);
        for (int k = 0; k < 4; k++) begin
            check("t2_pop_valid", valid, 1);
            check("t2_pop_data", data, 8'h41 + 8'(k));
            tick(1'b1, 1'b1, 1'b0);
            tick(1'b1, 1'b0, 1'b0);
        end
        check("t2_empty", valid, 0);
        check("t2_ferr", ferr_cnt, 0);

        // 3: short low glitch from idle
        do_reset();
        check("t3_ovf_cleared", ovf, 0);
        mon_clear();
        repeat (20) tick(1'b0, 1'b1, 1'b0);
        idle(12 * C, 1'b1);
        check("t3_no_byte", vcount, 0);
        check("t3_no_ferr", ferr_cnt, 0);
        check("t3_no_ovf", ovf, 0);

        // 4: framing error then a clean frame
        mon_clear();
        send_frame(8'hA5, 1'b0, 3 * C, 1'b1, -1, -1);
        check("t4_ferr_count", ferr_cnt, 1);
        check("t4_ferr_at", ferr_at, VALID_AT);
        check("t4_no_push", vcount, 0);
        idle(C, 1'b1);
        mon_clear();
        send_frame(8'h3C, 1'b1, C, 1'b1, -1, -1);
        idle(20, 1'b1);
        check("t4_next_rise", vfirst, VALID_AT);
        check("t4_next_data", vdata, 8'h3C);
        check("t4_next_len", vcount, 1);
        check("t4_next_ferr", ferr_cnt, 0);

        // 5: reset during data bit 4 with two bytes queued
        mon_clear();
        send_frame(8'h11, 1'b1, C, 1'b0, -1, -1);
        send_frame(8'h22, 1'b1, C, 1'b0, -1, -1);
        idle(3, 1'b0);
        check("t5_queued", valid, 1);
        check("t5_queued_head", data, 8'h11);
        send_frame(8'hFF, 1'b1, C, 1'b0, -1, 5 * C + 35);
        idle(1, 1'b0);
        check("t5_valid_after_rst", valid, 0);
        check("t5_data_after_rst", data, 8'h00);
        mon_clear();
        send_frame(8'h12, 1'b1, C, 1'b1, -1, -1);
        idle(20, 1'b1);
        check("t5_next_rise", vfirst, VALID_AT);
        check("t5_next_data", vdata, 8'h12);
        check("t5_next_pops", popq.size(), 1);

        // 6: push+pop while full, then 16 bytes through pointer wrap
        mon_clear();
        for (int k = 0; k < 4; k++) send_frame(8'(k), 1'b1, C, 1'b0, -1, -1);
        check("t6_full_valid", valid, 1);
        send_frame(8'h04, 1'b1, C, 1'b0, VALID_AT - 1, -1);
        check("t6_no_ovf_push_pop", ovf, 0);
        check("t6_head_after", data, 8'h01);
        for (int k = 5; k < 16; k++) send_frame(8'(k), 1'b1, C, 1'b1, -1, -1);
        idle(20, 1'b1);
        check("t6_pop_count", popq.size(), 16);
        for (int k = 0; k < 16; k++) begin
            if (k < popq.size()) check("t6_order", popq[k], 8'(k));
        end
        check("t6_ovf_end", ovf, 0);
        check("t6_drained", valid, 0);

        $display("End of test - %0d assertions evaluated, %0d failures", n_assert, n_fail);
        $finish;
    end

endmodule
